// File: rtl/regfile_multiport_sb_pkg.sv
// Shared constants and helpers for the multiport register file and its scoreboard.
// Defaults reproduce the core's original register file layout (SP in x2, halt watch on x17).
package rf_pkg;
    localparam int          XLEN_DEF      = 32;
    localparam int          NUM_REGS_DEF  = 32;
    localparam int          NUM_RD_DEF    = 2;
    localparam int          SP_IDX_DEF    = 2;
    localparam logic [31:0] SP_INIT_DEF   = 32'h0000_2ffc;
    localparam int          WATCH_IDX_DEF = 17;
    localparam logic [31:0] WATCH_VAL_DEF = 32'd10;
    localparam int          REG_ZERO      = 0;

    function automatic int addr_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction
endpackage

// File: rtl/regfile_multiport_sb_if.sv
// Decode/writeback-facing bus of the register file: read ports, write port, issue and watch.
interface regfile_multiport_sb_if
    import rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF
);
    localparam int AW = addr_width(NUM_REGS);

    logic [NUM_RD*AW-1:0]   rs_addr;
    logic [NUM_RD*XLEN-1:0] rs_dout;
    logic [NUM_RD-1:0]      rs_busy;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [XLEN-1:0]        wr_data;
    logic                   iss_en;
    logic [AW-1:0]          iss_rd;
    logic                   flush;
    logic                   watch_hit;

    modport master (
        output rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
        input  rs_dout, rs_busy, watch_hit
    );

    modport slave (
        input  rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
        output rs_dout, rs_busy, watch_hit
    );
endinterface

// File: rtl/regfile_multiport_sb_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, flush wipes; issue beats clear.
// Also answers the per-read-port "operand still in flight" lookup.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int BYPASS   = 1,
    parameter int AW       = addr_width(NUM_REGS)
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_rd,
    input  logic                 flush,
    input  logic [NUM_RD*AW-1:0] rs_addr,
    output logic [NUM_RD-1:0]    rs_busy
);
    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            if (gi == REG_ZERO) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_live
                logic set_hit;
                logic clr_hit;
                assign set_hit = iss_en && (iss_rd == AW'(gi));
                assign clr_hit = wr_en && (wr_addr == AW'(gi));
                // An issue in the same cycle is a new producer, so it outlives both clear and flush.
                assign busy_next[gi] = set_hit | (~flush & busy_reg[gi] & ~clr_hit);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_lookup
            logic [AW-1:0] addr;
            logic          byp_hit;
            assign addr        = rs_addr[gi*AW +: AW];
            // A writeback being forwarded this cycle already satisfies the operand.
            assign byp_hit     = (BYPASS != 0) && wr_en && (wr_addr == addr);
            assign rs_busy[gi] = busy_reg[addr] & ~byp_hit;
        end
    endgenerate
endmodule

// File: rtl/regfile_multiport_sb.sv
// Integer register file: NUM_RD combinational read ports with optional write bypass,
// one synchronous write port, busy scoreboard and a registered halt-watch comparator.
module regfile_multiport_sb
    import rf_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter int              NUM_REGS  = NUM_REGS_DEF,
    parameter int              NUM_RD    = NUM_RD_DEF,
    parameter int              BYPASS    = 1,
    parameter int              SP_IDX    = SP_IDX_DEF,
    parameter logic [XLEN-1:0] SP_INIT   = XLEN'(SP_INIT_DEF),
    parameter int              WATCH_IDX = WATCH_IDX_DEF,
    parameter logic [XLEN-1:0] WATCH_VAL = XLEN'(WATCH_VAL_DEF)
)(
    input  logic                  clk,
    input  logic                  reset,
    regfile_multiport_sb_if.slave rf
);
    localparam int AW = addr_width(NUM_REGS);

    logic [XLEN-1:0] rf_reg [NUM_REGS];
    logic [XLEN-1:0] watch_src;
    logic            watch_hit_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_reg[i] <= (i == SP_IDX && SP_IDX != REG_ZERO) ? SP_INIT : '0;
            end
        end else if (rf.wr_en && (rf.wr_addr != AW'(REG_ZERO))) begin
            rf_reg[rf.wr_addr] <= rf.wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic          byp_hit;
            assign addr    = rf.rs_addr[gi*AW +: AW];
            assign byp_hit = (BYPASS != 0) && rf.wr_en && (rf.wr_addr == addr);
            assign rf.rs_dout[gi*XLEN +: XLEN] = (addr == AW'(REG_ZERO)) ? '0 :
                                                 byp_hit                 ? rf.wr_data :
                                                                           rf_reg[addr];
        end
    endgenerate

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .BYPASS   (BYPASS),
        .AW       (AW)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rf.wr_en),
        .wr_addr (rf.wr_addr),
        .iss_en  (rf.iss_en),
        .iss_rd  (rf.iss_rd),
        .flush   (rf.flush),
        .rs_addr (rf.rs_addr),
        .rs_busy (rf.rs_busy)
    );

    // Compare against the value the watched register will hold after this edge,
    // so watch_hit lines up with the register contents rather than lagging a cycle.
    always_comb begin
        watch_src = rf_reg[WATCH_IDX];
        if (WATCH_IDX != REG_ZERO && rf.wr_en && (rf.wr_addr == AW'(WATCH_IDX))) begin
            watch_src = rf.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            watch_hit_reg <= 1'b0;
        end else begin
            watch_hit_reg <= (watch_src == WATCH_VAL);
        end
    end

    assign rf.watch_hit = watch_hit_reg;
endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Drives a bypassing and a non-bypassing register file with identical stimulus and
// checks both against a behavioural model of registers, busy bits and watch flag.
module tb_regfile_multiport_sb;
    import rf_pkg::*;

    localparam int          AW        = 5;
    localparam int          WATCH_IDX = 17;
    localparam logic [31:0] WATCH_VAL = 32'd10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  rs_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        flush;

    always #5 clk = ~clk;

    regfile_multiport_sb_if #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2)) if_b0 ();
    regfile_multiport_sb_if #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2)) if_b1 ();

    assign if_b0.rs_addr = rs_addr;  assign if_b1.rs_addr = rs_addr;
    assign if_b0.wr_en   = wr_en;    assign if_b1.wr_en   = wr_en;
    assign if_b0.wr_addr = wr_addr;  assign if_b1.wr_addr = wr_addr;
    assign if_b0.wr_data = wr_data;  assign if_b1.wr_data = wr_data;
    assign if_b0.iss_en  = iss_en;   assign if_b1.iss_en  = iss_en;
    assign if_b0.iss_rd  = iss_rd;   assign if_b1.iss_rd  = iss_rd;
    assign if_b0.flush   = flush;    assign if_b1.flush   = flush;

    regfile_multiport_sb #(.BYPASS(0)) dut_b0 (.clk(clk), .reset(reset), .rf(if_b0));
    regfile_multiport_sb #(.BYPASS(1)) dut_b1 (.clk(clk), .reset(reset), .rf(if_b1));

    logic [63:0] dout_q  [2];
    logic [1:0]  busy_q  [2];
    logic        watch_q [2];
    assign dout_q[0]  = if_b0.rs_dout;   assign dout_q[1]  = if_b1.rs_dout;
    assign busy_q[0]  = if_b0.rs_busy;   assign busy_q[1]  = if_b1.rs_busy;
    assign watch_q[0] = if_b0.watch_hit; assign watch_q[1] = if_b1.watch_hit;

    // Reference model: architectural state only.
    logic [31:0] m_rf [32];
    bit          m_busy [32];
    bit          m_watch;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] exp_dout(input int byp, input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (byp != 0 && wr_en && wr_addr == a) return wr_data;
        return m_rf[a];
    endfunction

    function automatic logic exp_busy(input int byp, input logic [4:0] a);
        if (byp != 0 && wr_en && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_edge();
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                m_rf[i]   = 32'd0;
                m_busy[i] = 1'b0;
            end
            m_rf[2] = 32'h2ffc;
            m_watch = 1'b0;
        end else begin
            if (wr_en && wr_addr != 5'd0) m_rf[wr_addr] = wr_data;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (wr_en) begin
                m_busy[wr_addr] = 1'b0;
            end
            if (iss_en && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
            m_watch = (m_rf[WATCH_IDX] == WATCH_VAL);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        iss_en = 1'b0; iss_rd = 5'd0; flush = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0]  a;
        logic [31:0] want;
        idle();
        rs_addr = 10'd0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs_addr = {5'(31 - i), 5'(i)};
            #1;
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < 2; p++) begin
                    a = rs_addr[p*AW +: AW];
                    want = (a == 5'd2) ? 32'h2ffc : 32'd0;
                    total++;
                    if (dout_q[b][p*32 +: 32] !== want) begin
                        bad++;
                        $display("FAIL reset_dout b%0d p%0d addr=%0d got=%h want=%h", b, p, a, dout_q[b][p*32 +: 32], want);
                    end
                    total++;
                    if (busy_q[b][p] !== 1'b0) begin
                        bad++;
                        $display("FAIL reset_busy b%0d p%0d addr=%0d got=%b want=0", b, p, a, busy_q[b][p]);
                    end
                end
                total++;
                if (watch_q[b] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_watch b%0d got=%b want=0", b, watch_q[b]);
                end
            end
            tick();
        end
        $display("test_reset: checked all 32 addresses after reset");
    endtask

    task automatic test_zero_reg();
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 0) begin
                wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hdead;
                iss_en = 1'b1; iss_rd = 5'd0;
            end else begin
                idle();
            end
            rs_addr = 10'd0;
            #1;
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < 2; p++) begin
                    total++;
                    if (dout_q[b][p*32 +: 32] !== 32'd0 || busy_q[b][p] !== 1'b0) begin
                        bad++;
                        $display("FAIL zero_reg b%0d p%0d phase%0d got=%h/%b want=0/0", b, p, phase, dout_q[b][p*32 +: 32], busy_q[b][p]);
                    end
                end
            end
            tick();
        end
        $display("test_zero_reg: write and issue to x0 ignored");
    endtask

    task automatic test_bypass();
        logic [31:0] old_val;
        idle();
        old_val = m_rf[5];
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234;
        rs_addr = {5'd5, 5'd5};
        #1;
        total++;
        if (dout_q[1][31:0] !== 32'h1234) begin
            bad++;
            $display("FAIL bypass_same_cycle b1 got=%h want=%h", dout_q[1][31:0], 32'h1234);
        end
        total++;
        if (dout_q[0][31:0] !== old_val) begin
            bad++;
            $display("FAIL nobypass_same_cycle b0 got=%h want=%h", dout_q[0][31:0], old_val);
        end
        tick();
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            total++;
            if (dout_q[b][63:32] !== 32'h1234) begin
                bad++;
                $display("FAIL bypass_next_cycle b%0d got=%h want=%h", b, dout_q[b][63:32], 32'h1234);
            end
        end
        tick();
        $display("test_bypass: x5 write forwarding checked");
    endtask

    task automatic test_scoreboard();
        // step: {wr_en, wr_addr, iss_en, iss_rd, flush}
        int st_wr   [10] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        int st_wra  [10] = '{0, 0, 7, 0, 7, 0, 0, 0, 0, 0};
        int st_iss  [10] = '{1, 0, 1, 0, 0, 0, 1, 1, 0, 0};
        int st_issr [10] = '{7, 0, 7, 0, 0, 0, 7, 9, 0, 0};
        int st_fl   [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        logic [4:0] a;
        logic       want;
        rs_addr = {5'd9, 5'd7};
        for (int s = 0; s < 10; s++) begin
            wr_en = st_wr[s][0]; wr_addr = 5'(st_wra[s]); wr_data = $urandom;
            iss_en = st_iss[s][0]; iss_rd = 5'(st_issr[s]); flush = st_fl[s][0];
            #1;
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < 2; p++) begin
                    a = rs_addr[p*AW +: AW];
                    want = exp_busy(b, a);
                    total++;
                    if (busy_q[b][p] !== want) begin
                        bad++;
                        $display("FAIL sb_step%0d b%0d x%0d got=%b want=%b", s, b, a, busy_q[b][p], want);
                    end
                end
            end
            if (s == 3 || s == 8) begin
                total++;
                if (busy_q[0] !== ((s == 3) ? 2'b01 : 2'b10)) begin
                    bad++;
                    $display("FAIL sb_fixed_step%0d got=%b want=%b", s, busy_q[0], (s == 3) ? 2'b01 : 2'b10);
                end
            end
            tick();
        end
        $display("test_scoreboard: issue/clear/flush sequence on x7/x9");
    endtask

    task automatic test_watch();
        logic want [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        rs_addr = {5'd17, 5'd17};
        for (int s = 0; s < 4; s++) begin
            idle();
            if (s == 0 || s == 2) begin
                wr_en = 1'b1; wr_addr = 5'd17; wr_data = (s == 0) ? 32'd10 : 32'd11;
            end
            #1;
            for (int b = 0; b < 2; b++) begin
                total++;
                if (watch_q[b] !== want[s]) begin
                    bad++;
                    $display("FAIL watch_step%0d b%0d got=%b want=%b", s, b, watch_q[b], want[s]);
                end
            end
            tick();
        end
        $display("test_watch: x17=10 raises, x17=11 drops watch_hit");
    endtask

    task automatic test_reset_mid();
        idle();
        wr_en = 1'b1; wr_addr = 5'd17; wr_data = 32'd10;
        iss_en = 1'b1; iss_rd = 5'd4;
        tick();
        reset = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'habcd;
        iss_en = 1'b1; iss_rd = 5'd4;
        tick();
        reset = 1'b1;
        idle();
        for (int i = 0; i < 32; i++) begin
            rs_addr = {5'(i), 5'd3};
            #1;
            for (int b = 0; b < 2; b++) begin
                total++;
                if (busy_q[b][1] !== 1'b0) begin
                    bad++;
                    $display("FAIL midreset_busy b%0d x%0d got=%b want=0", b, i, busy_q[b][1]);
                end
                if (i == 0) begin
                    total++;
                    if (dout_q[b][31:0] !== 32'd0) begin
                        bad++;
                        $display("FAIL midreset_x3 b%0d got=%h want=0", b, dout_q[b][31:0]);
                    end
                    total++;
                    if (watch_q[b] !== 1'b0) begin
                        bad++;
                        $display("FAIL midreset_watch b%0d got=%b want=0", b, watch_q[b]);
                    end
                end
            end
            tick();
        end
        $display("test_reset_mid: in-flight write/issue discarded by reset");
    endtask

    function automatic logic [4:0] rnd_addr();
        logic [4:0] a;
        if ($urandom_range(0, 3) == 0) begin
            a = 5'($urandom_range(0, 31));
        end else begin
            a = 5'($urandom_range(0, 7));
            if (a == 5'd7) a = 5'd17;
        end
        return a;
    endfunction

    task automatic test_random();
        logic [4:0]  a;
        logic [31:0] wd;
        logic        wb;
        int          errs_before;
        for (int n = 0; n < 400; n++) begin
            errs_before = bad;
            reset   = ($urandom_range(0, 49) != 0);
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = rnd_addr();
            wr_data = ($urandom_range(0, 3) == 0) ? 32'd10 : 32'($urandom);
            iss_en  = ($urandom_range(0, 2) == 0);
            iss_rd  = rnd_addr();
            flush   = ($urandom_range(0, 15) == 0);
            rs_addr = {rnd_addr(), rnd_addr()};
            #1;
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < 2; p++) begin
                    a  = rs_addr[p*AW +: AW];
                    wd = exp_dout(b, a);
                    wb = exp_busy(b, a);
                    total++;
                    if (dout_q[b][p*32 +: 32] !== wd) begin
                        bad++;
                        $display("FAIL rnd_dout n%0d b%0d p%0d x%0d got=%h want=%h", n, b, p, a, dout_q[b][p*32 +: 32], wd);
                    end
                    total++;
                    if (busy_q[b][p] !== wb) begin
                        bad++;
                        $display("FAIL rnd_busy n%0d b%0d p%0d x%0d got=%b want=%b", n, b, p, a, busy_q[b][p], wb);
                    end
                end
                total++;
                if (watch_q[b] !== m_watch) begin
                    bad++;
                    $display("FAIL rnd_watch n%0d b%0d got=%b want=%b", n, b, watch_q[b], m_watch);
                end
            end
            $display("rnd %0d: rst=%b wr=%b x%0d=%h iss=%b x%0d fl=%b rd=x%0d,x%0d errs=%0d",
                     n, reset, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
                     rs_addr[4:0], rs_addr[9:5], bad - errs_before);
            tick();
        end
        reset = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        rs_addr = 10'd0;
        test_reset();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_watch();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
